// File: rtl/hs_npu_mm_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : hs_npu_mm_drain_if
// Brief    : Skewed lane inputs and aligned-row valid/ready output bundle for
//            the matrix-multiply drain stage.
// Revision : 1.0 - initial release
// ============================================================================
interface hs_npu_mm_drain_if #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 32
);
  logic [SIZE-1:0][DATA_WIDTH-1:0] lane_data_i;
  logic [SIZE-1:0]                 lane_valid_i;
  logic [SIZE-1:0][DATA_WIDTH-1:0] row_data_o;
  logic                            row_valid_o;
  logic                            row_ready_i;

  // Drain-side view: consumes lane words, produces rows.
  modport slave (
    input  lane_data_i,
    input  lane_valid_i,
    input  row_ready_i,
    output row_data_o,
    output row_valid_o
  );

  // Environment view: produces lane words, consumes rows.
  modport master (
    output lane_data_i,
    output lane_valid_i,
    output row_ready_i,
    input  row_data_o,
    input  row_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/hs_npu_mm_drain.sv
`default_nettype none
// ============================================================================
// Module   : hs_npu_mm_drain
// Brief    : De-skews per-lane systolic results into whole rows, presents them
//            on valid/ready and pulses done once the programmed rows drain.
//            Optional macro HS_NPU_DRAIN_RELU_EN clamps negative outputs to 0.
// Revision : 1.0 - initial release
// ============================================================================
module hs_npu_mm_drain #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LANE_DEPTH = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        flush_i,
  input  wire logic        start_i,
  input  wire logic [31:0] rows_total_i,
  hs_npu_mm_drain_if.slave bus,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o
);

  localparam int PTR_W = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
  localparam int CNT_W = $clog2(LANE_DEPTH + 1);
  localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(LANE_DEPTH - 1);
  localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(LANE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SIZE-1:0]                 w_nonempty;
  logic [SIZE-1:0]                 w_full;
  logic [SIZE-1:0]                 w_push;
  logic [SIZE-1:0]                 w_drop;
  logic [SIZE-1:0][DATA_WIDTH-1:0] w_head;
  logic [SIZE-1:0][DATA_WIDTH-1:0] w_row_data;
  logic                            w_accept;
  logic                            w_row_valid;
  logic                            w_pop;
  logic                            w_last_row;
  logic [PTR_W-1:0]                r_rd_ptr;
  logic [31:0]                     r_rows_total;
  logic [31:0]                     r_rows_done;
  logic                            r_overflow;

  // Flush wins over traffic, so nothing is stored or flagged in that cycle.
  assign w_accept    = (r_state == ST_DRAIN) && !flush_i;
  assign w_row_valid = (r_state == ST_DRAIN) && (&w_nonempty);
  assign w_pop       = w_row_valid && bus.row_ready_i;
  assign w_last_row  = (r_rows_done + 32'd1) == r_rows_total;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_mem [LANE_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_cnt;

    assign w_nonempty[i] = (r_cnt != '0);
    assign w_full[i]     = (r_cnt == c_DEPTH);
    assign w_push[i]     = w_accept && bus.lane_valid_i[i] && (!w_full[i] || w_pop);
    assign w_drop[i]     = w_accept && bus.lane_valid_i[i] && w_full[i] && !w_pop;
    assign w_head[i]     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
      if (w_push[i]) begin
        r_mem[r_wr_ptr] <= bus.lane_data_i[i];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
        r_wr_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push[i]) begin
          r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
        end
        case ({w_push[i], w_pop})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    // Output is zero whenever no complete row is presented.
`ifdef HS_NPU_DRAIN_RELU_EN
    assign w_row_data[i] = (!w_row_valid || w_head[i][DATA_WIDTH-1]) ? '0 : w_head[i];
`else
    assign w_row_data[i] = w_row_valid ? w_head[i] : '0;
`endif
  end

  assign bus.row_data_o  = w_row_data;
  assign bus.row_valid_o = w_row_valid;
  assign overflow_o      = r_overflow;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = (rows_total_i == 32'd0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        if (w_pop && w_last_row) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush_i) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      r_rows_total <= '0;
      r_rows_done  <= '0;
      r_overflow   <= 1'b0;
    end else if (r_state == ST_IDLE && start_i) begin
      r_rows_total <= rows_total_i;
      r_rows_done  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rows_done <= r_rows_done + 32'd1;
      end
      if (|w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/hs_npu_mm_drain.md
Name: hs_npu_mm_drain

Overview:
- Sink-side counterpart of the matrix-multiply unit's output path.
- Takes the diagonally skewed per-lane results (lane i arrives i cycles after lane 0, each lane with its own valid) and re-aligns them into whole output rows.
- Presents those rows on a valid/ready handshake to the downstream writeback stage.
- Counts rows against a programmed total and raises a done pulse when the layer's output has fully drained.

Parameters:
- SIZE, 8, number of lanes; equals the systolic array dimension.
- DATA_WIDTH, 32, width of each result word (two's complement).
- LANE_DEPTH, 16, entries per lane skew buffer; must be >= SIZE.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- flush_i  input  1  clear all lane buffers and the row counter; return to IDLE
- start_i  input  1  one-cycle pulse; latches rows_total_i and begins draining
- rows_total_i  input  32 (uword)  number of rows expected for this job
- lane_data_i[SIZE]  input  DATA_WIDTH each  skewed result words
- lane_valid_i[SIZE]  input  1 each  per-lane valid; no backpressure upstream
- row_data_o[SIZE]  output  DATA_WIDTH each  aligned output row
- row_valid_o  output  1  row_data_o holds a complete row
- row_ready_i  input  1  downstream accepts the row
- busy_o  output  1  state is DRAIN
- done_o  output  1  one-cycle pulse when the last row is accepted
- overflow_o  output  1  sticky: a lane word was dropped

Behaviour:
- Reset is synchronous: when rst_n = 0 at a rising edge of clk, the block resets.
  - state = IDLE; all lane buffers empty; row counter = 0.
  - row_valid_o = 0, busy_o = 0, done_o = 0, overflow_o = 0.
  - row_data_o = 0.
- Reset mid-job discards all buffered data; no done pulse is generated.
- Lane buffers:
  - One circular FIFO per lane: LANE_DEPTH entries, independent write pointer, shared pop.
  - A word is written when lane_valid_i[i] = 1 and state = DRAIN.
  - In IDLE or DONE, lane_valid_i is ignored and no overflow is flagged.
- Row formation:
  - row_valid_o = 1 exactly when every lane FIFO is non-empty and state = DRAIN.
  - row_data_o[i] = head of lane i.
  - A row word written on cycle N (the last lane to complete the row) appears with row_valid_o = 1 on cycle N+1.
  - Pop all lanes together on row_valid_o && row_ready_i.
  - row_data_o and row_valid_o are held stable while row_valid_o && !row_ready_i.
- Simultaneous push and pop on a lane in the same cycle:
  - Always allowed, including when that lane is full.
  - Occupancy is unchanged.
- Overflow:
  - Condition: lane full, lane_valid_i[i] = 1, and no pop that cycle.
  - Effect: the word is dropped, overflow_o is set, other lanes are unaffected.
  - overflow_o clears only on reset, flush_i, or start_i.
- FSM:
  - IDLE -> DRAIN on start_i. Latch rows_total_i, clear row count, clear overflow_o.
  - IDLE -> DONE directly when start_i arrives with rows_total_i = 0. done_o pulses the following cycle.
  - DRAIN: increment the row count on each accepted row. When the accepted row makes count == total, go to DONE.
  - DONE: done_o = 1 for exactly one cycle, then go to IDLE.
  - start_i during DRAIN or DONE is ignored.
- flush_i:
  - Takes priority over start_i and over all traffic.
  - Next cycle: buffers empty, state = IDLE, row_valid_o = 0, overflow_o = 0.
- Words arriving after the last row is accepted are not stored. The state is no longer DRAIN.
- Pointer wrap: pointers roll over at LANE_DEPTH-1 -> 0, with separate full/empty tracking (count per lane).

Optional Feature:
- Macro: HS_NPU_DRAIN_RELU_EN.
- When defined:
  - Each row_data_o[i] whose sign bit is set is driven as 0. Non-negative values pass unchanged.
  - The clamp is combinational on the FIFO head, so latency is unchanged.
  - Buffered contents keep the raw value.
- When undefined: row_data_o is the raw head word.

Test Plan:
- Reset/idle:
  - Stimulus: after reset, drive lane_valid_i = 1 on all lanes for 5 cycles without start_i.
  - Response: row_valid_o stays 0, overflow_o stays 0, busy_o = 0.
- Skewed row alignment (SIZE = 8):
  - Stimulus: start_i with rows_total_i = 2. Lane i receives value 10*i+r for row r at cycle r+i. row_ready_i = 1.
  - Response: row 0 = {0,10,...,70} valid at cycle 8; row 1 = {1,11,...,71} at cycle 9; done_o pulses at cycle 10; then IDLE.
- Backpressure:
  - Stimulus: same traffic as the alignment case, with row_ready_i = 0 for 6 cycles after row 0 appears.
  - Response: row 0 held stable; row 1 follows on the cycle after the release; no data loss; overflow_o = 0.
- Overflow:
  - Stimulus: LANE_DEPTH = 16, row_ready_i = 0, 17 words pushed into lane 0 only.
  - Response: overflow_o = 1 after the 17th word; lane 0 head still the first word; other lanes unaffected.
- Zero rows and flush:
  - Stimulus: start_i with rows_total_i = 0.
  - Response: done_o pulses one cycle later.
  - Stimulus: flush_i asserted mid-DRAIN with 3 words buffered.
  - Response: next cycle buffers empty, state IDLE, no done_o.
- ReLU (HS_NPU_DRAIN_RELU_EN defined):
  - Stimulus: row {-5, 7, 0x80000000, 3, ...}.
  - Response: row_data_o = {0, 7, 0, 3, ...}.
  - Undefined: raw values output.
